adc_sample_rx: RTL

- Capture side of the audio path: reads an external 12-bit serial ADC (AD7476-class on a Pmod header) once per sample-rate clock enable.
- Converts the offset-binary code to a signed 16-bit left-justified sample for the 16-bit filter chain.
- Mirror of the existing output path, which turns signed samples back into offset-binary for the DAC pins.
- Runs on the 19.8 MHz system clock, driven by the same `en` strobe as the tone generator and filters.

---
 rtl/adc_sample_rx_if.sv | 49 ++++
 rtl/adc_sample_rx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/adc_sample_rx_if.sv
// adc_sample_rx_if: bundles the serial ADC pins and the sample-side outputs of
// adc_sample_rx.
//   master : the capture block (drives ADC cs_n/sclk and the sample outputs)
//   slave  : the surroundings (drive en and the ADC data line, observe the rest)
// Signals:
//   en        sample strobe, one cycle
//   adc_miso  serial data from the ADC
//   adc_cs_n  ADC chip select, active low
//   adc_sclk  ADC serial clock, idles high
//   dout      signed left-justified 16-bit sample
//   valid     one-cycle pulse when dout updates
//   busy      frame or quiet period in progress
//   overrun   one-cycle pulse for an en that arrived while busy
//   fmt_err   sticky leading-bit error flag
interface adc_sample_rx_if;
    logic        en;
    logic        adc_miso;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [15:0] dout;
    logic        valid;
    logic        busy;
    logic        overrun;
    logic        fmt_err;

    modport master (
        input  en,
        input  adc_miso,
        output adc_cs_n,
        output adc_sclk,
        output dout,
        output valid,
        output busy,
        output overrun,
        output fmt_err
    );

    modport slave (
        output en,
        output adc_miso,
        input  adc_cs_n,
        input  adc_sclk,
        input  dout,
        input  valid,
        input  busy,
        input  overrun,
        input  fmt_err
    );
endinterface

// File: rtl/adc_sample_rx.sv
// adc_sample_rx: reads one 16-bit frame from a 12-bit serial ADC per en strobe
// and turns the offset-binary code into a signed, left-justified 16-bit sample.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    adc_sample_rx_if.master (en, adc_miso in; adc_cs_n, adc_sclk, dout,
//          valid, busy, overrun, fmt_err out)
// Parameters:
//   CLK_DIV    SCLK half-period in clk cycles (>= 1)
//   QUIET_CYC  cs_n-high cycles after a frame before the next may start (>= 1)
// Frame timing (en seen in cycle T): cs_n low from T+1, sclk high for CLK_DIV
// cycles then toggling every CLK_DIV cycles, 16 rising edges, valid in cycle
// T+2+32*CLK_DIV, then QUIET_CYC quiet cycles before returning to idle.
module adc_sample_rx #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned QUIET_CYC = 4
) (
    input logic            clk,
    input logic            reset,
    adc_sample_rx_if.master bus
);

    localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned QuietW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
    localparam logic [DivW-1:0]   DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [QuietW-1:0] QuietLast = QuietW'(QUIET_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StDone,
        StQuiet
    } state_e;

    state_e            state_q;
    logic [DivW-1:0]   div_cnt_q;
    logic [3:0]        bit_cnt_q;
    logic [QuietW-1:0] quiet_cnt_q;
    logic [15:0]       shift_q;
    logic              cs_n_q;
    logic              sclk_q;
    logic [15:0]       dout_q;
    logic              valid_q;
    logic              busy_q;
    logic              overrun_q;
    logic              fmt_err_q;

    logic [15:0] shift_next;
    logic        sample_now;

    // Shift register contents including the bit being sampled this cycle, so
    // the final conversion can happen on the same edge as the last sample.
    assign shift_next = {shift_q[14:0], bus.adc_miso};

    // First cycle of each sclk high phase is the rising-edge sample point.
    assign sample_now = (state_q == StShift) && sclk_q && (div_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            quiet_cnt_q <= '0;
            shift_q     <= '0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            fmt_err_q   <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            // Any en outside idle, including the last quiet cycle, is dropped.
            overrun_q <= bus.en && (state_q != StIdle);

            case (state_q)
                StIdle: begin
                    if (bus.en) begin
                        state_q   <= StSetup;
                        cs_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                    end
                end

                StSetup: begin
                    if (div_cnt_q == DivLast) begin
                        div_cnt_q <= '0;
                        sclk_q    <= 1'b0;
                        state_q   <= StShift;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end

                StShift: begin
                    if (div_cnt_q == DivLast) begin
                        div_cnt_q <= '0;
                        sclk_q    <= ~sclk_q;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end

                    if (sample_now) begin
                        shift_q   <= shift_next;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 4'd15) begin
                            // Last bit: close the frame and park sclk high,
                            // overriding the toggle above when CLK_DIV is 1.
                            state_q   <= StDone;
                            cs_n_q    <= 1'b1;
                            sclk_q    <= 1'b1;
                            valid_q   <= 1'b1;
                            // Offset binary to two's complement: flip the MSB.
                            dout_q    <= {~shift_next[11], shift_next[10:0], 4'b0000};
                            fmt_err_q <= fmt_err_q | (|shift_next[15:12]);
                        end
                    end
                end

                StDone: begin
                    state_q     <= StQuiet;
                    quiet_cnt_q <= '0;
                end

                StQuiet: begin
                    if (quiet_cnt_q == QuietLast) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        quiet_cnt_q <= quiet_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.adc_cs_n = cs_n_q;
    assign bus.adc_sclk = sclk_q;
    assign bus.dout     = dout_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;
    assign bus.fmt_err  = fmt_err_q;

endmodule
